// File: rtl/add_result_checker_if.sv
// Handshake/bus bundle between the adder BFM harness and the add_result_checker scoreboard.
interface add_result_checker_if;
  logic        start_i;
  logic        op_valid_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        res_valid_i;
  logic [7:0]  res_i;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [31:0] pass_cnt_o;
  logic [31:0] err_cnt_o;
  logic        overflow_o;
  logic        underflow_o;
  logic [31:0] first_err_idx_o;
  logic [7:0]  first_err_exp_o;
  logic [7:0]  first_err_got_o;

  modport master (
    output start_i, op_valid_i, a_i, b_i, res_valid_i, res_i,
    input  busy_o, done_o, pass_o, pass_cnt_o, err_cnt_o, overflow_o, underflow_o,
           first_err_idx_o, first_err_exp_o, first_err_got_o
  );

  modport slave (
    input  start_i, op_valid_i, a_i, b_i, res_valid_i, res_i,
    output busy_o, done_o, pass_o, pass_cnt_o, err_cnt_o, overflow_o, underflow_o,
           first_err_idx_o, first_err_exp_o, first_err_got_o
  );
endinterface

// File: rtl/add_result_checker.sv
// In-order scoreboard for the 8-bit adder BFM: queues expected sums, checks results, counts N_TXN.
// Optional first-error capture is enabled by defining ADD_CHK_ERR_CAPTURE_EN.
module add_result_checker #(
  parameter int unsigned N_TXN = 2000,
  parameter int unsigned DEPTH = 8
) (
  input logic                 clk_i,
  input logic                 reset_ni,
  add_result_checker_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] chk_cnt, pass_cnt, err_cnt;
  logic        overflow, underflow, busy, done;

  logic        empty, full, run, start_run;
  logic        do_check, do_pop, do_push, is_err;
  logic [7:0]  head, sum;

  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    run       = (state == RUN);
    start_run = (state != RUN) && bus.start_i;
    head      = mem[rd_ptr[AW-1:0]];
    sum       = bus.a_i + bus.b_i;
    do_check  = run && bus.res_valid_i;
    do_pop    = do_check && !empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is then legal.
    do_push   = run && bus.op_valid_i && (!full || do_pop);
    is_err    = do_check && (empty || (head != bus.res_i));
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= sum;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      chk_cnt   <= '0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (start_run) begin
      state     <= RUN;
      busy      <= 1'b1;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      chk_cnt   <= '0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (run) begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (bus.op_valid_i && full && !do_pop) overflow <= 1'b1;
      if (do_check) begin
        chk_cnt <= chk_cnt + 32'd1;
        if (empty) underflow <= 1'b1;
        else       rd_ptr    <= rd_ptr + 1'b1;
        if (is_err) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        end else begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 32'd1;
        end
        if (chk_cnt == 32'(N_TXN - 1)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef ADD_CHK_ERR_CAPTURE_EN
  logic [31:0] cap_idx;
  logic [7:0]  cap_exp, cap_got;

  // err_cnt never returns to zero within a run, so it doubles as the "no error yet" flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cap_idx <= '0;
      cap_exp <= '0;
      cap_got <= '0;
    end else if (start_run) begin
      cap_idx <= '0;
      cap_exp <= '0;
      cap_got <= '0;
    end else if (is_err && (err_cnt == '0)) begin
      cap_idx <= chk_cnt;
      cap_exp <= empty ? 8'd0 : head;
      cap_got <= bus.res_i;
    end
  end

  assign bus.first_err_idx_o = cap_idx;
  assign bus.first_err_exp_o = cap_exp;
  assign bus.first_err_got_o = cap_got;
`else
  assign bus.first_err_idx_o = '0;
  assign bus.first_err_exp_o = '0;
  assign bus.first_err_got_o = '0;
`endif

  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.pass_o      = done && (err_cnt == '0) && !overflow && !underflow;
  assign bus.pass_cnt_o  = pass_cnt;
  assign bus.err_cnt_o   = err_cnt;
  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;

endmodule

// File: tb/tb_add_result_checker.sv
// Directed bench for add_result_checker: queue-based reference model compared every cycle,
// plus literal expectations taken from hand-worked transaction sequences.
module tb_add_result_checker;

  localparam int unsigned N_TXN = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_result_checker_if bus();

  add_result_checker #(.N_TXN(N_TXN), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expectations held in a plain queue, outcomes tallied per the checking rules.
  logic [7:0]  exp_q[$];
  bit          m_run, m_done, m_ovf, m_unf, m_had_err;
  logic [31:0] m_pass, m_err, m_chk, cap_idx;
  logic [7:0]  cap_exp, cap_got;

  task automatic model_clear();
    exp_q.delete();
    m_run = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_had_err = 0;
    m_pass = 0; m_err = 0; m_chk = 0;
    cap_idx = 0; cap_exp = 0; cap_got = 0;
  endtask

  task automatic model_error(input logic [7:0] expv);
    if (!m_had_err) begin
      m_had_err = 1;
      cap_idx = m_chk - 1;
      cap_exp = expv;
      cap_got = bus.res_i;
    end
    if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] e;
    logic [7:0] s;
    if (!rst_n) begin
      model_clear();
    end else if (!m_run) begin
      if (bus.start_i) begin
        model_clear();
        m_run = 1;
      end
    end else begin
      if (bus.res_valid_i) begin
        m_chk = m_chk + 1;
        if (exp_q.size() == 0) begin
          m_unf = 1;
          model_error(8'd0);
        end else begin
          e = exp_q.pop_front();
          if (e == bus.res_i) begin
            if (m_pass != 32'hFFFF_FFFF) m_pass = m_pass + 1;
          end else begin
            model_error(e);
          end
        end
        if (m_chk == N_TXN) begin
          m_run = 0;
          m_done = 1;
        end
      end
      if (bus.op_valid_i) begin
        s = bus.a_i + bus.b_i;
        if (exp_q.size() < DEPTH) exp_q.push_back(s);
        else m_ovf = 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at t=%0t", name, got, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("busy_o",      32'(bus.busy_o),      32'(m_run));
    check_output("done_o",      32'(bus.done_o),      32'(m_done));
    check_output("pass_o",      32'(bus.pass_o),      32'(m_done && m_err == 0 && !m_ovf && !m_unf));
    check_output("pass_cnt_o",  bus.pass_cnt_o,       m_pass);
    check_output("err_cnt_o",   bus.err_cnt_o,        m_err);
    check_output("overflow_o",  32'(bus.overflow_o),  32'(m_ovf));
    check_output("underflow_o", 32'(bus.underflow_o), 32'(m_unf));
`ifdef ADD_CHK_ERR_CAPTURE_EN
    check_output("first_err_idx_o", bus.first_err_idx_o,     cap_idx);
    check_output("first_err_exp_o", 32'(bus.first_err_exp_o), 32'(cap_exp));
    check_output("first_err_got_o", 32'(bus.first_err_got_o), 32'(cap_got));
`else
    check_output("first_err_idx_o", bus.first_err_idx_o,     32'd0);
    check_output("first_err_exp_o", 32'(bus.first_err_exp_o), 32'd0);
    check_output("first_err_got_o", 32'(bus.first_err_got_o), 32'd0);
`endif
  end

  task automatic apply_stimulus(input logic start, input logic opv, input logic [7:0] a,
                                input logic [7:0] b, input logic resv, input logic [7:0] res);
    @(negedge clk);
    bus.start_i     = start;
    bus.op_valid_i  = opv;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.res_valid_i = resv;
    bus.res_i       = res;
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 8'd0, 8'd0, 0, 8'd0);
  endtask

  task automatic pulse_start();
    apply_stimulus(1, 0, 8'd0, 8'd0, 0, 8'd0);
    idle();
  endtask

  // Pairs (1,2) (255,1) (200,100) (0,0); BFM answers one cycle after each issue.
  task automatic run_pairs(input logic [7:0] third_res);
    apply_stimulus(0, 1, 8'd1,   8'd2,   0, 8'd0);
    apply_stimulus(0, 1, 8'd255, 8'd1,   1, 8'd3);
    apply_stimulus(0, 1, 8'd200, 8'd100, 1, 8'd0);
    apply_stimulus(0, 1, 8'd0,   8'd0,   1, third_res);
    apply_stimulus(0, 0, 8'd0,   8'd0,   1, 8'd0);
    idle();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done_o) return;
    end
    check_output("done_timeout", 32'(bus.done_o), 32'd1);
  endtask

  initial begin
    bus.start_i = 0; bus.op_valid_i = 0; bus.a_i = 0; bus.b_i = 0;
    bus.res_valid_i = 0; bus.res_i = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_output("rst_busy",     32'(bus.busy_o),     32'd0);
    check_output("rst_pass_cnt", bus.pass_cnt_o,      32'd0);
    check_output("rst_pass_o",   32'(bus.pass_o),     32'd0);
    rst_n = 1;

    // Clean run; the operand offered with start must be ignored.
    apply_stimulus(1, 1, 8'd9, 8'd9, 0, 8'd0);
    idle();
    check_output("t1_busy", 32'(bus.busy_o), 32'd1);
    run_pairs(8'd44);
    wait_done();
    check_output("t1_pass_cnt", bus.pass_cnt_o,  32'd4);
    check_output("t1_err_cnt",  bus.err_cnt_o,   32'd0);
    check_output("t1_done",     32'(bus.done_o), 32'd1);
    check_output("t1_pass",     32'(bus.pass_o), 32'd1);
    check_output("t1_model_pass", m_pass, 32'd4);
    apply_stimulus(0, 1, 8'd3, 8'd3, 1, 8'd99);
    idle();
    check_output("t1_after_done_err", bus.err_cnt_o, 32'd0);

    // Restart from DONE with the third result corrupted.
    pulse_start();
    check_output("t2_cleared", bus.pass_cnt_o, 32'd0);
    run_pairs(8'd45);
    wait_done();
    check_output("t2_err_cnt",  bus.err_cnt_o,   32'd1);
    check_output("t2_pass_cnt", bus.pass_cnt_o,  32'd3);
    check_output("t2_pass",     32'(bus.pass_o), 32'd0);
`ifdef ADD_CHK_ERR_CAPTURE_EN
    check_output("t2_first_idx", bus.first_err_idx_o,      32'd2);
    check_output("t2_first_exp", 32'(bus.first_err_exp_o), 32'd44);
    check_output("t2_first_got", 32'(bus.first_err_got_o), 32'd45);
`endif

    // Five pushes into a 4-deep FIFO, then the four retained sums 11..14.
    pulse_start();
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 8'(10 + i), 8'd1, 0, 8'd0);
    idle();
    check_output("t3_overflow", 32'(bus.overflow_o), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 8'd0, 8'd0, 1, 8'(11 + i));
    idle();
    wait_done();
    check_output("t3_pass_cnt", bus.pass_cnt_o,  32'd4);
    check_output("t3_err_cnt",  bus.err_cnt_o,   32'd0);
    check_output("t3_pass",     32'(bus.pass_o), 32'd0);

    // Result with an empty FIFO alongside the first push; the pushed 11 must survive as head.
    pulse_start();
    apply_stimulus(0, 1, 8'd5, 8'd6, 1, 8'd9);
    apply_stimulus(0, 0, 8'd0, 8'd0, 1, 8'd11);
    idle();
    check_output("t4_underflow", 32'(bus.underflow_o), 32'd1);
    check_output("t4_err_cnt",   bus.err_cnt_o,        32'd1);
    check_output("t4_pass_cnt",  bus.pass_cnt_o,       32'd1);
`ifdef ADD_CHK_ERR_CAPTURE_EN
    check_output("t4_first_idx", bus.first_err_idx_o,      32'd0);
    check_output("t4_first_exp", 32'(bus.first_err_exp_o), 32'd0);
    check_output("t4_first_got", 32'(bus.first_err_got_o), 32'd9);
`endif

    // Reset mid-run, away from any clock edge.
    apply_stimulus(0, 1, 8'd1, 8'd1, 0, 8'd0);
    idle();
    #2 rst_n = 0;
    #1;
    check_output("t5_busy",      32'(bus.busy_o),      32'd0);
    check_output("t5_done",      32'(bus.done_o),      32'd0);
    check_output("t5_pass_cnt",  bus.pass_cnt_o,       32'd0);
    check_output("t5_err_cnt",   bus.err_cnt_o,        32'd0);
    check_output("t5_underflow", 32'(bus.underflow_o), 32'd0);
    check_output("t5_first_got", 32'(bus.first_err_got_o), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Clean run after reset; a start pulse inside RUN must be ignored.
    pulse_start();
    apply_stimulus(0, 1, 8'd1,   8'd2,   0, 8'd0);
    apply_stimulus(1, 1, 8'd255, 8'd1,   1, 8'd3);
    apply_stimulus(0, 1, 8'd200, 8'd100, 1, 8'd0);
    apply_stimulus(0, 1, 8'd0,   8'd0,   1, 8'd44);
    apply_stimulus(0, 0, 8'd0,   8'd0,   1, 8'd0);
    idle();
    wait_done();
    check_output("t6_pass_cnt", bus.pass_cnt_o,  32'd4);
    check_output("t6_err_cnt",  bus.err_cnt_o,   32'd0);
    check_output("t6_pass",     32'(bus.pass_o), 32'd1);

    idle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
